// File: rtl/vinyl_fx_pkg.sv
// Shared types, constants and the saturating helper for the multi-channel vinyl effect.
package vinyl_fx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DECAY,
    ST_HOLDOFF
  } pop_state_t;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  // Clamp a (dw+2)-bit signed sum to the signed dw-bit range; the result is
  // sign-extended to 32 bits so callers keep the low dw bits.
  function automatic logic signed [31:0] sat_add(input logic signed [33:0] sum,
                                                 input int unsigned dw);
    logic signed [33:0] hi;
    logic signed [33:0] lo;
    hi = (34'sd1 <<< (dw - 1)) - 34'sd1;
    lo = -(34'sd1 <<< (dw - 1));
    if (sum > hi)      sat_add = hi[31:0];
    else if (sum < lo) sat_add = lo[31:0];
    else               sat_add = sum[31:0];
  endfunction

endpackage

// File: rtl/vinyl_fx_mc_lfsr.sv
// 32-bit Galois LFSR (right-shifting) with a reset seed; a zero seed would lock up, so it becomes 1.
module vinyl_lfsr32
  import vinyl_fx_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [31:0] lfsr_o
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      lfsr_q <= SEED_EFF;
    else if (adv_i) lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/vinyl_fx_mc.sv
// Multi-channel vinyl effect: LFSR hiss, pop/crackle FSM with holdoff, per-channel saturating mix.
module vinyl_fx_mc
  import vinyl_fx_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          NUM_CH      = 2,
  parameter int          TICK_DIV    = 1042,
  parameter int          HISS_SHIFT  = 7,
  parameter int          POP_SHIFT   = 3,
  parameter int          DECAY_SHIFT = 8,
  parameter logic [31:0] POP_THRESH  = 32'h7FFEB9C0,
  parameter int          HOLDOFF     = 64,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     hiss_en,
  input  logic                     pop_en,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     sample_tick,
  output logic                     pop_active
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [TW-1:0]            tick_cnt_q;
  logic                     sample_tick_q;
  logic [31:0]              lfsr;
  logic signed [DATA_W-1:0] noise;
  logic signed [DATA_W-1:0] hiss;
  logic signed [DATA_W-1:0] pop_val_q;
  logic signed [DATA_W-1:0] pop_step;
  logic [HW-1:0]            holdoff_cnt_q;
  pop_state_t               state_q;
  logic                     pop_active_q;
  logic                     trigger;
  logic signed [DATA_W+1:0] hiss_x;
  logic signed [DATA_W+1:0] pop_x;

  // Free-running sample divider, independent of enable.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick_cnt_q    <= '0;
      sample_tick_q <= 1'b0;
    end else if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
      tick_cnt_q    <= '0;
      sample_tick_q <= 1'b1;
    end else begin
      tick_cnt_q    <= tick_cnt_q + TW'(1);
      sample_tick_q <= 1'b0;
    end
  end

  vinyl_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .adv_i  (enable),
    .lfsr_o (lfsr)
  );

  assign noise    = lfsr[31 -: DATA_W];
  assign hiss     = noise >>> HISS_SHIFT;
  assign pop_step = pop_val_q >>> DECAY_SHIFT;
  assign trigger  = enable & pop_en & ($signed(lfsr) > $signed(POP_THRESH));

  // Only IDLE->ARMED reacts to any cycle; everything else waits for a sample tick.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset || !enable) begin
      state_q       <= ST_IDLE;
      pop_val_q     <= '0;
      holdoff_cnt_q <= '0;
      pop_active_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (trigger) begin
          state_q      <= ST_ARMED;
          pop_active_q <= 1'b1;
        end
        ST_ARMED: if (sample_tick_q) begin
          pop_val_q <= noise >>> POP_SHIFT;
          state_q   <= ST_DECAY;
        end
        ST_DECAY: if (sample_tick_q) begin
          if (pop_step == '0 || pop_step == '1) begin
            pop_val_q     <= '0;
            holdoff_cnt_q <= HW'(HOLDOFF);
            state_q       <= ST_HOLDOFF;
            pop_active_q  <= 1'b0;
          end else begin
            pop_val_q <= pop_val_q - pop_step;
          end
        end
        ST_HOLDOFF: if (sample_tick_q) begin
          if (holdoff_cnt_q <= HW'(1)) begin
            holdoff_cnt_q <= '0;
            state_q       <= ST_IDLE;
          end else begin
            holdoff_cnt_q <= holdoff_cnt_q - HW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hiss_x = hiss_en ? (DATA_W+2)'(hiss) : '0;
  assign pop_x  = pop_en ? (DATA_W+2)'(pop_val_q) : '0;

  // Mono crackle: every channel sees the same hiss and pop terms.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [DATA_W-1:0] in_s;
    logic signed [DATA_W+1:0] sum;
    logic signed [31:0]       sat;
    logic [DATA_W-1:0]        out_q;

    assign in_s = $signed(in_data[k*DATA_W +: DATA_W]);
    assign sum  = (DATA_W+2)'(in_s) + hiss_x + pop_x;
    assign sat  = sat_add(34'(sum), DATA_W);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)        out_q <= '0;
      else if (!enable) out_q <= in_data[k*DATA_W +: DATA_W];
      else              out_q <= sat[DATA_W-1:0];
    end

    assign out_data[k*DATA_W +: DATA_W] = out_q;
  end

  assign sample_tick = sample_tick_q;
  assign pop_active  = pop_active_q;

endmodule

// File: tb/tb_vinyl_fx_mc.sv
// Bench: two effect instances (default 32-bit stereo, small 16-bit 3-channel pop config) vs a behavioural model.
module tb_vinyl_fx_mc;

  typedef struct {
    int     dw, nch, tdiv, hs, ps, ds, hold;
    longint thresh;
    logic [31:0] seed;
  } cfg_t;

  typedef struct {
    logic [31:0]  lfsr;
    int           tcnt;
    bit           tick;
    int           st;     // 0 idle, 1 armed, 2 decay, 3 holdoff
    longint       popv;
    int           hold;
    bit           pact;
    logic [255:0] out;
  } mdl_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rstA, enA, hA, pA, tickA, pactA;
  logic [63:0] inA, outA;
  logic        rstB, enB, hB, pB, tickB, pactB;
  logic [47:0] inB, outB;

  int checks, errs, cycA;
  cfg_t cA, cB;
  mdl_t mA, mB;

  vinyl_fx_mc u_a (
    .CLOCK_50(clk), .reset(rstA), .enable(enA), .hiss_en(hA), .pop_en(pA),
    .in_data(inA), .out_data(outA), .sample_tick(tickA), .pop_active(pactA)
  );

  vinyl_fx_mc #(
    .DATA_W(16), .NUM_CH(3), .TICK_DIV(8), .DECAY_SHIFT(4),
    .POP_THRESH(32'h80000000), .HOLDOFF(2), .SEED(32'h1)
  ) u_b (
    .CLOCK_50(clk), .reset(rstB), .enable(enB), .hiss_en(hB), .pop_en(pB),
    .in_data(inB), .out_data(outB), .sample_tick(tickB), .pop_active(pactB)
  );

  function automatic mdl_t mdl_reset(cfg_t c);
    mdl_t n;
    n.lfsr = (c.seed == 32'h0) ? 32'h1 : c.seed;
    n.tcnt = 0; n.tick = 0; n.st = 0; n.popv = 0; n.hold = 0; n.pact = 0; n.out = '0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(cfg_t c, mdl_t m, bit en, bit he, bit pe, logic [255:0] din);
    mdl_t n = m;
    longint noise, s, lim, msk, d;
    logic [31:0] raw, t;
    noise = longint'($signed(m.lfsr)) >>> (32 - c.dw);
    lim   = longint'(1) <<< (c.dw - 1);
    msk   = (longint'(1) <<< c.dw) - 1;
    n.out = '0;
    for (int k = 0; k < c.nch; k++) begin
      raw = 32'(din >> (k * c.dw));
      t   = raw << (32 - c.dw);
      s   = longint'($signed(t)) >>> (32 - c.dw);
      if (en) begin
        if (he) s += noise >>> c.hs;
        if (pe) s += m.popv;
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
      end
      n.out |= 256'(s & msk) << (k * c.dw);
    end
    n.tick = (m.tcnt == c.tdiv - 1);
    n.tcnt = (m.tcnt + 1) % c.tdiv;
    if (en) n.lfsr = m.lfsr[0] ? ((m.lfsr >> 1) ^ 32'h80200003) : (m.lfsr >> 1);
    if (!en) begin
      n.st = 0; n.popv = 0; n.hold = 0;
    end else begin
      case (m.st)
        0: if (pe && longint'($signed(m.lfsr)) > c.thresh) n.st = 1;
        1: if (m.tick) begin n.popv = noise >>> c.ps; n.st = 2; end
        2: if (m.tick) begin
          d = m.popv >>> c.ds;
          if (d == 0 || d == -1) begin n.popv = 0; n.hold = c.hold; n.st = 3; end
          else n.popv = m.popv - d;
        end
        default: if (m.tick) begin
          n.hold = m.hold - 1;
          if (n.hold <= 0) begin n.hold = 0; n.st = 0; end
        end
      endcase
    end
    n.pact = (n.st == 1 || n.st == 2);
    return n;
  endfunction

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: advance both models with the inputs held across the edge, then compare.
  task automatic cyc();
    @(posedge clk);
    mA = rstA ? mdl_reset(cA) : mdl_step(cA, mA, enA, hA, pA, 256'(inA));
    mB = rstB ? mdl_reset(cB) : mdl_step(cB, mB, enB, hB, pB, 256'(inB));
    if (!rstA) cycA++;
    #1;
    chk("outA", 256'(outA), mA.out);
    chk("tickA", 256'(tickA), 256'(mA.tick));
    chk("pactA", 256'(pactA), 256'(mA.pact));
    chk("outB", 256'(outB), mB.out);
    chk("tickB", 256'(tickB), 256'(mB.tick));
    chk("pactB", 256'(pactB), 256'(mB.pact));
    chk("tickA_period", 256'(tickA), 256'(cycA > 0 && cycA % 1042 == 0));
  endtask

  task automatic rnd_in();
    inA = {$urandom, $urandom};
    inB = 48'({$urandom, $urandom});
  endtask

  initial begin
    bit found;
    checks = 0; errs = 0; cycA = 0;
    cA = '{dw:32, nch:2, tdiv:1042, hs:7, ps:3, ds:8, hold:64,
           thresh:longint'($signed(32'h7FFEB9C0)), seed:32'hACE12468};
    cB = '{dw:16, nch:3, tdiv:8, hs:7, ps:3, ds:4, hold:2,
           thresh:longint'($signed(32'h80000000)), seed:32'h1};
    rstA = 1; rstB = 1;
    enA = 0; hA = 0; pA = 0; inA = '0;
    enB = 0; hB = 0; pB = 0; inB = '0;
    mA = mdl_reset(cA); mB = mdl_reset(cB);

    #25;
    chk("rst_outA", 256'(outA), 256'(0));
    chk("rst_tickA", 256'(tickA), 256'(0));
    chk("rst_pactA", 256'(pactA), 256'(0));
    chk("rst_outB", 256'(outB), 256'(0));
    chk("rst_tickB", 256'(tickB), 256'(0));
    chk("rst_pactB", 256'(pactB), 256'(0));

    // Release both; B always triggers so it must arm on the very first edge.
    enA = 1; hA = 1; pA = 1; enB = 1; hB = 1; pB = 1;
    rnd_in();
    rstA = 0; rstB = 0;
    cyc();
    chk("armed_first", 256'(pactB), 256'(1));
    for (int i = 0; i < 2100; i++) begin
      rnd_in();
      hB = ($urandom % 4) != 0;
      pB = ($urandom % 8) != 0;
      cyc();
    end

    // Bypass with frozen LFSR, then hiss-only from the held LFSR state.
    enA = 0; inA = {32'hFFFF0000, 32'h12345678};
    cyc();
    chk("bypassA_first", 256'(outA), 256'({32'hFFFF0000, 32'h12345678}));
    for (int i = 0; i < 100; i++) cyc();
    chk("bypassA_hold", 256'(outA), 256'({32'hFFFF0000, 32'h12345678}));
    enA = 1; hA = 1; pA = 0; inA = '0;
    for (int i = 0; i < 50; i++) cyc();

    // Saturation at both rails: outputs must clamp, never wrap sign.
    inA = {32'h80000005, 32'h7FFFFFF0};
    for (int i = 0; i < 300; i++) begin
      cyc();
      chk("sat_ch0_sign", 256'(outA[31]), 256'(0));
      chk("sat_ch1_sign", 256'(outA[63]), 256'(1));
    end

    for (int i = 0; i < 1200; i++) begin
      rnd_in();
      enA = ($urandom % 10) != 0; hA = $urandom % 2; pA = $urandom % 2;
      enB = ($urandom % 10) != 0; hB = $urandom % 2; pB = ($urandom % 4) != 0;
      cyc();
    end

    // Reset B in the middle of a live decay.
    enA = 1; enB = 1; pB = 1; hB = 1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      rnd_in();
      cyc();
      found = (mB.st == 2 && mB.popv != 0);
    end
    chk("decay_reached", 256'(found), 256'(1));
    rstB = 1;
    #1;
    mB = mdl_reset(cB);
    chk("midrst_outB", 256'(outB), 256'(0));
    chk("midrst_pactB", 256'(pactB), 256'(0));
    chk("midrst_tickB", 256'(tickB), 256'(0));
    for (int i = 0; i < 3; i++) cyc();
    rstB = 0;
    for (int i = 0; i < 300; i++) begin
      rnd_in();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
